// File: rtl/byte_gather.sv
// Reassembles LANES numbers of BYTES bytes each from a byte-lane serial link,
// least-significant byte first, and publishes each group through valid/ready.
module byte_gather #(
  parameter int LANES = 4,
  parameter int BYTES = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  input  logic                            in_sop,
  input  logic [LANES*8-1:0]              in_data,
  output logic                            in_ready,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [LANES-1:0][BYTES*8-1:0]   out_number,
  output logic                            align_err
);

  localparam int BW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BYTES - 1);

  logic [BW-1:0]                  beat;
  logic [BW-1:0]                  slot;
  logic [LANES-1:0][BYTES*8-1:0]  asm_q;
  logic [LANES-1:0][BYTES*8-1:0]  asm_next;
  logic                           accept;
  logic                           is_drop;
  logic                           is_store;
  logic                           is_complete;
  logic                           is_err;

  // Only the final beat can stall: it is the one that would overwrite out_number.
  assign in_ready = (beat != LAST_BEAT) || !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // A sop beat always restarts the group at slot 0; a non-sop beat at slot 0 is dropped.
  assign slot        = in_sop ? '0 : beat;
  assign is_drop     = !in_sop && (beat == '0);
  assign is_store    = accept && !is_drop;
  assign is_complete = is_store && (slot == LAST_BEAT);
  assign is_err      = accept && (in_sop ? (beat != '0) : (beat == '0));

  always_comb begin
    asm_next = asm_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      asm_next[i][{slot, 3'b000} +: 8] = in_data[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      beat       <= '0;
      asm_q      <= '0;
      out_number <= '0;
      out_valid  <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      if (is_store) begin
        asm_q <= asm_next;
        beat  <= is_complete ? '0 : slot + BW'(1);
      end

      if (is_complete) begin
        out_number <= asm_next;
        out_valid  <= 1'b1;
      end else if (out_ready) begin
        out_valid  <= 1'b0;
      end

      if (is_err) begin
        align_err <= 1'b1;
      end
    end
  end

endmodule
